// File: rtl/sradd_sched.sv
// ---------------------------------------------------------------------------
// sradd_sched
//   Round-robin scheduler that shares one same-sign single-precision FP adder
//   (sradd) among NREQ requesters. At most one request is granted per cycle.
//   The granted operands are registered into stage 0 and the result travels
//   down a LAT-deep pipe. Results return on one shared response bus, tagged
//   with the requester id. Throughput is one add per cycle.
//
//   Latency: the accepting edge loads stage 0, and each following edge
//   advances one stage. resp_valid therefore rises on the LAT-th edge,
//   counting the accepting edge as the first. With LAT=1 the response is
//   visible right after the accepting edge.
//
// Ports
//   clk         in   1        clock, rising edge
//   rst         in   1        asynchronous, active-high reset
//   en          in   1        1 = grants allowed; 0 = no new grants, pipe drains
//   req_valid   in   NREQ     per-requester request
//   req_a       in   32*NREQ  operand a, requester i at [32*i+31:32*i]
//   req_b       in   32*NREQ  operand b, same packing as req_a
//   req_ready   out  NREQ     one-hot grant; accepted when valid[i] & ready[i]
//   resp_valid  out  1        one-cycle pulse per completed add
//   resp_id     out  IDW      requester index of this result
//   resp_z      out  32       sradd(a,b) result
//   resp_err    out  1        operand signs differed; z not a valid sum
//   busy        out  1        any pipeline stage holds a valid op
// ---------------------------------------------------------------------------
module sradd_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 resp_valid,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_z,
  output logic                 resp_err,
  output logic                 busy
);

  localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  logic [IDW-1:0]  r_ptr;
  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gnt_id;
  logic            w_found;

  assign w_elig = req_valid & {NREQ{en}};

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path leaves a variable unassigned (no latch).
  always_comb begin
    logic [IDW:0] idx;
    w_found  = 1'b0;
    w_gnt_id = '0;
    w_grant  = '0;
    idx      = '0;
    // Scan ptr, ptr+1, ... modulo NREQ; one extra bit keeps the sum from
    // overflowing before the modulo correction (works for non-power-of-2).
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!w_found && w_elig[idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_gnt_id = idx[IDW-1:0];
      end
    end
    if (w_found) w_grant[w_gnt_id] = 1'b1;
  end

  assign req_ready = rst ? '0 : w_grant;

  // NOTE: sequential state is updated with non-blocking '<=' only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_id == LAST_ID) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Stage 0: operand capture
  // -------------------------------------------------------------------------
  logic [31:0]    w_sel_a, w_sel_b;
  logic           w_sel_err;
  logic           r_s0_vld;
  logic [31:0]    r_s0_a, r_s0_b;
  logic [IDW-1:0] r_s0_id;
  logic           r_s0_err;

  assign w_sel_a = req_a[{w_gnt_id, 5'b0} +: 32];
  assign w_sel_b = req_b[{w_gnt_id, 5'b0} +: 32];
  // A zero operand is a legal pass-through even with a negative partner.
  assign w_sel_err = (w_sel_a[31] ^ w_sel_b[31]) & (|w_sel_a) & (|w_sel_b);

  // NOTE: data registers are reset here (not just the valids) because the
  // response bus must read zero during and after reset; they load only when
  // their stage's valid loads 1 so the outputs hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s0_vld <= 1'b0;
      r_s0_a   <= '0;
      r_s0_b   <= '0;
      r_s0_id  <= '0;
      r_s0_err <= 1'b0;
    end else begin
      r_s0_vld <= w_found;
      if (w_found) begin
        r_s0_a   <= w_sel_a;
        r_s0_b   <= w_sel_b;
        r_s0_id  <= w_gnt_id;
        r_s0_err <= w_sel_err;
      end
    end
  end

  // -------------------------------------------------------------------------
  // sradd: same-sign adder, combinational on the stage-0 registers.
  // Magnitudes are added and the result takes a's sign. Zero (and subnormal)
  // operands pass the other operand through; Inf/NaN operands pass through;
  // overflow saturates to Inf. The aligned sum is truncated.
  // -------------------------------------------------------------------------
  logic [31:0] w_z;

  always_comb begin
    logic [7:0]  ea, eb, e_big, d;
    logic [23:0] m_big, m_small;
    logic [24:0] sum;
    logic        a_ge_b;
    ea      = r_s0_a[30:23];
    eb      = r_s0_b[30:23];
    a_ge_b  = (r_s0_a[30:0] >= r_s0_b[30:0]);
    e_big   = a_ge_b ? ea : eb;
    d       = a_ge_b ? (ea - eb) : (eb - ea);
    m_big   = {1'b1, a_ge_b ? r_s0_a[22:0] : r_s0_b[22:0]};
    m_small = {1'b1, a_ge_b ? r_s0_b[22:0] : r_s0_a[22:0]};
    sum     = {1'b0, m_big} + {1'b0, m_small >> d};
    w_z     = '0;
    if (ea == 8'h00) begin
      w_z = r_s0_b;
    end else if (eb == 8'h00) begin
      w_z = r_s0_a;
    end else if (ea == 8'hFF) begin
      w_z = r_s0_a;
    end else if (eb == 8'hFF) begin
      w_z = r_s0_b;
    end else if (sum[24]) begin
      // Carry out of the hidden bit: renormalise by one place.
      if (e_big == 8'hFE) w_z = {r_s0_a[31], 8'hFF, 23'h0};
      else                w_z = {r_s0_a[31], e_big + 8'd1, sum[23:1]};
    end else begin
      w_z = {r_s0_a[31], e_big, sum[22:0]};
    end
  end

  // -------------------------------------------------------------------------
  // Stages 1..LAT-1 and output selection
  // -------------------------------------------------------------------------
  generate
    if (LAT == 1) begin : g_lat1
      assign resp_valid = r_s0_vld;
      assign resp_id    = r_s0_id;
      assign resp_z     = w_z;
      assign resp_err   = r_s0_err;
      assign busy       = r_s0_vld;
    end else begin : g_latn
      logic [LAT-1:1] r_vld;
      logic [31:0]    r_z   [LAT-1:1];
      logic [IDW-1:0] r_id  [LAT-1:1];
      logic           r_err [LAT-1:1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= '0;
          for (int s = 1; s < LAT; s++) begin
            r_z[s]   <= '0;
            r_id[s]  <= '0;
            r_err[s] <= 1'b0;
          end
        end else begin
          r_vld[1] <= r_s0_vld;
          if (r_s0_vld) begin
            r_z[1]   <= w_z;
            r_id[1]  <= r_s0_id;
            r_err[1] <= r_s0_err;
          end
          for (int s = 2; s < LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            if (r_vld[s-1]) begin
              r_z[s]   <= r_z[s-1];
              r_id[s]  <= r_id[s-1];
              r_err[s] <= r_err[s-1];
            end
          end
        end
      end

      assign resp_valid = r_vld[LAT-1];
      assign resp_id    = r_id[LAT-1];
      assign resp_z     = r_z[LAT-1];
      assign resp_err   = r_err[LAT-1];
      assign busy       = r_s0_vld | (|r_vld);
    end
  endgenerate

endmodule
